imem_loader: RTL and testbench

Boot-time writer for the 16-entry, 16-bit instruction memory of the single-cycle MIPS core. It takes a byte stream over a valid/ready handshake and assembles 16-bit instruction words. It writes them to the instruction RAM write port at sequential addresses and checks a trailing XOR checksum. While loading it holds the core in reset, and releases it only after a successful load.

---
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader for the core's instruction RAM. It assembles a counted byte stream
// into 16-bit words, writes them out, and releases the core after the checksum matches.
module imem_loader #(
  parameter int WORDS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_n
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        xor_q, xor_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              xfer;

  // Every output is decoded from the state alone, so in_ready never depends on in_valid.
  assign in_ready  = (state_q == S_COUNT) || (state_q == S_HI) ||
                     (state_q == S_LO)    || (state_q == S_CHK);
  assign xfer      = in_valid && in_ready;
  assign mem_we    = (state_q == S_WRITE);
  assign busy      = in_ready || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign cpu_rst_n = (state_q == S_DONE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      hi_q        <= '0;
      xor_q       <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      mem_addr_q  <= mem_addr_d;
      hi_q        <= hi_d;
      xor_q       <= xor_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    addr_d      = addr_q;
    mem_addr_d  = mem_addr_q;
    hi_d        = hi_q;
    xor_d       = xor_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_COUNT;
          addr_d  = '0;
          xor_d   = '0;
        end
      end
      S_COUNT: begin
        if (xfer) begin
          if ((in_data == 8'd0) || (in_data > 8'(WORDS))) begin
            state_d = S_ERR;
          end else begin
            count_d = in_data[CNT_W-1:0];
            xor_d   = xor_q ^ in_data;
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        if (xfer) begin
          hi_d    = in_data;
          xor_d   = xor_q ^ in_data;
          state_d = S_LO;
        end
      end
      // The write word and address are captured here so they are registered during WRITE.
      S_LO: begin
        if (xfer) begin
          mem_wdata_d = {hi_q, in_data};
          mem_addr_d  = addr_q;
          xor_d       = xor_q ^ in_data;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if ({1'b0, addr_q} == (count_q - CNT_W'(1))) begin
          state_d = S_CHK;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_HI;
        end
      end
      S_CHK: begin
        if (xfer) begin
          state_d = (in_data == xor_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the stimulus pushes expected RAM writes,
// and a negedge monitor pops and compares them whenever mem_we is seen.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_rst_n;

  int checks   = 0;
  int failures = 0;

  logic [19:0] expQ[$];
  logic [15:0] wordTab[16];

  imem_loader #(.WORDS(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Write monitor: each strobe must match the oldest expected write and never coexist with in_ready.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      checkOutput("readyInWrite", {31'd0, in_ready}, 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpectedWrite", {12'd0, mem_addr, mem_wdata}, 32'hFFFFFFFF);
      end else begin
        logic [19:0] e;
        e = expQ.pop_front();
        checkOutput("writeAddrData", {12'd0, mem_addr, mem_wdata}, {12'd0, e});
      end
    end
  end

  // Presents one byte starting at a negedge and returns at the negedge after it is accepted.
  task automatic applyStimulus(input logic [7:0] b, input bit gaps);
    int waitCnt;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        in_data = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    waitCnt  = 0;
    while (in_ready !== 1'b1 && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 100) checkOutput("readyTimeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic doStart(input bit expectAccepted);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (expectAccepted) begin
      checkOutput("startBusy", {31'd0, busy}, 32'd1);
      checkOutput("startReady", {31'd0, in_ready}, 32'd1);
      checkOutput("startClrDone", {30'd0, done, err}, 32'd0);
    end
  endtask

  task automatic checkResult(input bit good);
    checkOutput("resDone", {31'd0, done}, {31'd0, good});
    checkOutput("resErr", {31'd0, err}, {31'd0, !good});
    checkOutput("resCpuRst", {31'd0, cpu_rst_n}, {31'd0, good});
    checkOutput("resBusyReady", {30'd0, busy, in_ready}, 32'd0);
  endtask

  task automatic runLoad(input int n, input bit corrupt, input bit gaps);
    logic [7:0] chk;
    chk = 8'(n);
    doStart(1'b1);
    applyStimulus(8'(n), gaps);
    for (int i = 0; i < n; i++) begin
      expQ.push_back({4'(i), wordTab[i]});
      applyStimulus(wordTab[i][15:8], gaps);
      if (gaps && i == 0) begin
        repeat (20) begin
          in_data = 8'($urandom);
          @(negedge clk);
        end
      end
      applyStimulus(wordTab[i][7:0], gaps);
      chk = chk ^ wordTab[i][15:8] ^ wordTab[i][7:0];
    end
    if (corrupt) chk = chk ^ 8'h01;
    applyStimulus(chk, gaps);
    checkResult(!corrupt);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs",
                {12'd0, in_ready, mem_we, busy, done, err, cpu_rst_n, mem_addr, mem_wdata[9:0]},
                32'd0);
    checkOutput("resetWdata", {16'd0, mem_wdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Good load: 02 81 80 2C B2 9D
    $display("[TB] good load");
    wordTab[0] = 16'h8180;
    wordTab[1] = 16'h2CB2;
    runLoad(2, 1'b0, 1'b0);

    // Bad checksum (9C), then a new start clears err
    $display("[TB] bad checksum");
    runLoad(2, 1'b1, 1'b0);
    doStart(1'b1);

    // Bad count 00 from COUNT left by the start above
    $display("[TB] bad counts");
    applyStimulus(8'h00, 1'b0);
    checkResult(1'b0);
    doStart(1'b1);
    applyStimulus(8'h11, 1'b0);
    checkResult(1'b0);

    // Backpressure with random gaps and a 20-cycle stall mid-word
    $display("[TB] gapped load");
    runLoad(2, 1'b0, 1'b1);

    // start pulsed during HI must be ignored
    $display("[TB] start during HI");
    doStart(1'b1);
    expQ.push_back({4'd0, 16'h1234});
    applyStimulus(8'h01, 1'b0);
    doStart(1'b0);
    applyStimulus(8'h12, 1'b0);
    applyStimulus(8'h34, 1'b0);
    applyStimulus(8'h01 ^ 8'h12 ^ 8'h34, 1'b0);
    checkResult(1'b1);

    // Reset after the first word is written aborts the load
    $display("[TB] reset mid-load");
    doStart(1'b1);
    expQ.push_back({4'd0, 16'h8180});
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h81, 1'b0);
    applyStimulus(8'h80, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midResetOutputs",
                {12'd0, in_ready, mem_we, busy, done, err, cpu_rst_n, mem_addr, mem_wdata[9:0]},
                32'd0);
    checkOutput("midResetWdata", {16'd0, mem_wdata}, 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h2C;
    repeat (5) @(negedge clk);
    checkOutput("idleAfterReset", {29'd0, in_ready, busy, done}, 32'd0);
    in_valid = 1'b0;

    // Full 16-word load
    $display("[TB] full load");
    for (int i = 0; i < 16; i++) wordTab[i] = 16'h1000 + 16'(i) * 16'h0111;
    runLoad(16, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("allWritesSeen", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
